alu_sad_pe: RTL and testbench
=============================

Name: alu_sad_pe

Overview:
Pipelined processing element that computes packed sum-of-absolute-differences (SAD) per lane.
- Serves as the execute-side responder in the ALU block: it accepts operations from the PE switch over the execute handshake and returns results over the result handshake.
- Selected when the ALU xtype equals ALU_TYPE_SAD.
- Fixed 3-stage elastic pipeline, 1 op/cycle throughput, in-order.

Parameters:
NUM_LANES, 4, SIMD lanes per op
XLEN, 32, data width per lane; SAD8 covers XLEN/8 bytes, SAD16 covers XLEN/16 halfwords
TAG_WIDTH, 64, opaque sideband (uuid, wid, PC, rd, wb, pid, sop, eop), passed through unchanged

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
execute_valid  in  1  op available
execute_ready  out  1  PE accepts op this cycle
execute_op  in  2  0=SAD8, 1=SAD8_ACC, 2=SAD16, 3=reserved
execute_tmask  in  NUM_LANES  active lanes
execute_tag  in  TAG_WIDTH  sideband
execute_rs1  in  NUM_LANES*XLEN  operand A
execute_rs2  in  NUM_LANES*XLEN  operand B
execute_rs3  in  NUM_LANES*XLEN  accumulator input (SAD8_ACC only)
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_tmask  out  NUM_LANES  tmask of the op
result_tag  out  TAG_WIDTH  tag of the op
result_data  out  NUM_LANES*XLEN  per-lane results

Behaviour:
- Reset (reset=0, async): all stage valid bits = 0, result_valid = 0. result_data, result_tag and result_tmask = 0. execute_ready = 1 once reset deasserts.
- Ops in flight at reset are discarded, with no partial output after release.
- Handshake: a transfer occurs when valid && ready on a clock edge.
  - result_valid, once high, holds until accepted.
  - result_data, result_tag and result_tmask are stable while result_valid && !result_ready.
- Stages: S0 = input register, S1 = abs-diff register, S2 = output register (drives result_*).
  - Stage i advances when en_i = !v_i || en_(i+1). en_3 = result_ready.
  - execute_ready = en_0.
  - Bubbles collapse, so a stalled output does not block stages upstream that hold bubbles.
- Latency: an op accepted at edge N is presented as result_valid at edge N+3, provided no stall occurs.
- Throughput: 1 op/cycle with result_ready held high. With result_ready=0, at most 3 ops are held, then execute_ready=0.
- Arithmetic, per lane, all operands unsigned:
  - SAD8: sum over k of |A.byte[k] - B.byte[k]|, zero-extended to XLEN. Max 255*XLEN/8.
  - SAD8_ACC: the SAD8 value plus rs3, wrapping mod 2^XLEN.
  - SAD16: sum over halfwords of |A.h[k] - B.h[k]|, zero-extended to XLEN.
  - reserved (op=3): lane result = 0, no error signalled.
- Pipeline split:
  - S1 holds the per-byte differences, 9 bits each, as a sign-free magnitude. SAD16 reuses byte pairs with borrow.
  - S2 sums the adder tree and, for SAD8_ACC, adds rs3. rs3 is carried through S1.
- Inactive lanes (tmask bit = 0) yield result 0. tmask=0 still produces a result beat.
- Tag and tmask travel with their op. Ordering is strictly FIFO.
- Simultaneous accept and emit in the same cycle is legal at full rate.

Decomposition:
- Package VX_gpu_pkg gains:
  - ALU_TYPE_SAD (xtype encoding).
  - SAD_OP_SAD8 / SAD_OP_SAD8_ACC / SAD_OP_SAD16 / SAD_OP_RSVD (2-bit constants).
  - SAD_OP_BITS.
- Sub-module alu_sad_lane: the per-lane datapath for S1 and S2 (abs-diff, tree, accumulate). Stage-enable inputs come from the parent.
- The parent alu_sad_pe owns the valid/enable chain, tag and tmask registers, and the lane generate loop.

Test Plan:
- SAD8, lane0 rs1=0x01020304, rs2=0x04030201, tmask=0001 -> result_valid at edge N+3, lane0=0x00000008, lanes1-3=0.
- SAD8, rs1=0xFF00FF00, rs2=0x00FF00FF on all lanes -> every lane returns 0x000003FC.
- SAD8_ACC, rs1=0x01020304, rs2=0x04030201, rs3=0xFFFFFFFF -> 0x00000007 (wrap). SAD16, rs1=0xFFFF0000, rs2=0x0000FFFF -> 0x0001FFFE. op=3 -> 0.
- Back-pressure: result_ready=0 while 5 ops are offered back-to-back:
  - Exactly 3 are accepted, then execute_ready=0.
  - result_* are stable while stalled.
  - After result_ready=1, results appear in issue order with their matching tags, and the remaining 2 ops are accepted.
- Bubble collapse: op A, 2 idle cycles, op B, with result_ready=0 after A reaches S2 -> B advances to S1 while A is stalled in S2. B is not blocked behind the bubbles.
- Reset mid-flight: assert reset (low) with 3 ops in the pipe, asynchronously and between edges -> result_valid drops to 0 immediately. No stale result appears after release, and the first new op returns at N+3.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared ALU encodings plus the SAD processing-element op codes and helpers.
package VX_gpu_pkg;

  localparam int ALU_TYPE_BITS = 3;
  localparam logic [ALU_TYPE_BITS-1:0] ALU_TYPE_SAD = 3'd4;

  localparam int SAD_OP_BITS = 2;
  localparam logic [SAD_OP_BITS-1:0] SAD_OP_SAD8     = 2'd0;
  localparam logic [SAD_OP_BITS-1:0] SAD_OP_SAD8_ACC = 2'd1;
  localparam logic [SAD_OP_BITS-1:0] SAD_OP_SAD16    = 2'd2;
  localparam logic [SAD_OP_BITS-1:0] SAD_OP_RSVD     = 2'd3;

  localparam int SAD_STAGES = 3;

  // Unsigned byte |a-b| as a 9-bit magnitude (bit 8 is the borrow of a-b,
  // folded away by the conditional negate, so the result never exceeds 255).
  function automatic logic [8:0] sad_absdiff8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[8] ? (~d + 9'd1) : d;
  endfunction

endpackage

// File: rtl/alu_sad_lane.sv
// Per-lane SAD datapath: S1 abs-diff register, S2 adder tree + accumulate.
module alu_sad_lane
  import VX_gpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld1_i,
  input  logic                   ld2_i,
  input  logic [SAD_OP_BITS-1:0] op_i,
  input  logic                   act_i,
  input  logic [XLEN-1:0]        rs1_i,
  input  logic [XLEN-1:0]        rs2_i,
  input  logic [XLEN-1:0]        rs3_i,
  output logic [XLEN-1:0]        data_o
);

  localparam int NB = XLEN / 8;
  localparam int NH = XLEN / 16;

  logic [NB-1:0][8:0] mag_d, mag_q;
  logic [XLEN-1:0]    acc_d, acc_q;
  logic               half_d, half_q;
  logic [XLEN-1:0]    sum_d, data_q;

  // S1 next state: per-byte magnitudes; SAD16 chains byte pairs through the borrow
  always_comb begin
    logic [8:0]  lo, hi;
    logic [15:0] raw, mag16;
    mag_d = '0;
    lo    = '0;
    hi    = '0;
    raw   = '0;
    mag16 = '0;
    if (op_i == SAD_OP_SAD16) begin
      for (int h = 0; h < NH; h++) begin
        lo    = {1'b0, rs1_i[16*h +: 8]} - {1'b0, rs2_i[16*h +: 8]};
        hi    = {1'b0, rs1_i[16*h+8 +: 8]} - {1'b0, rs2_i[16*h+8 +: 8]} - {8'd0, lo[8]};
        raw   = {hi[7:0], lo[7:0]};
        mag16 = hi[8] ? (~raw + 16'd1) : raw;
        mag_d[2*h]   = {1'b0, mag16[7:0]};
        mag_d[2*h+1] = {1'b0, mag16[15:8]};
      end
    end else begin
      for (int k = 0; k < NB; k++)
        mag_d[k] = sad_absdiff8(rs1_i[8*k +: 8], rs2_i[8*k +: 8]);
    end
    // inactive lanes and the reserved op contribute nothing
    if (!act_i || op_i == SAD_OP_RSVD) mag_d = '0;
  end

  // accumulator rides along S1 only when it will be used, so S2 can add it blindly
  assign acc_d  = (act_i && op_i == SAD_OP_SAD8_ACC) ? rs3_i : '0;
  assign half_d = (op_i == SAD_OP_SAD16);

  // S1 register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_q  <= '0;
      acc_q  <= '0;
      half_q <= 1'b0;
    end else if (ld1_i) begin
      mag_q  <= mag_d;
      acc_q  <= acc_d;
      half_q <= half_d;
    end
  end

  // S2 next state: adder tree; halfword mode weights the odd byte by 256
  always_comb begin
    sum_d = acc_q;
    for (int h = 0; h < NH; h++) begin
      if (half_q)
        sum_d = sum_d + XLEN'(mag_q[2*h][7:0]) + (XLEN'(mag_q[2*h+1][7:0]) << 8);
      else
        sum_d = sum_d + XLEN'(mag_q[2*h]) + XLEN'(mag_q[2*h+1]);
    end
  end

  // S2 register, drives the lane result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     data_q <= '0;
    else if (ld2_i) data_q <= sum_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/alu_sad_pe.sv
// SAD processing element: 3-stage elastic pipeline (S0 input, S1 abs-diff,
// S2 output) with bubble-collapsing stage enables and in-order results.
module alu_sad_pe
  import VX_gpu_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      execute_valid,
  output logic                      execute_ready,
  input  logic [SAD_OP_BITS-1:0]    execute_op,
  input  logic [NUM_LANES-1:0]      execute_tmask,
  input  logic [TAG_WIDTH-1:0]      execute_tag,
  input  logic [NUM_LANES*XLEN-1:0] execute_rs1,
  input  logic [NUM_LANES*XLEN-1:0] execute_rs2,
  input  logic [NUM_LANES*XLEN-1:0] execute_rs3,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [NUM_LANES-1:0]      result_tmask,
  output logic [TAG_WIDTH-1:0]      result_tag,
  output logic [NUM_LANES*XLEN-1:0] result_data
);

  logic [SAD_STAGES-1:0] vld_pipe_q;
  logic                  en0, en1, en2;
  logic                  ld0, ld1, ld2;

  logic [SAD_OP_BITS-1:0]           op0_q;
  logic [NUM_LANES-1:0]             tmask0_q, tmask1_q, tmask2_q;
  logic [TAG_WIDTH-1:0]             tag0_q, tag1_q, tag2_q;
  logic [NUM_LANES-1:0][XLEN-1:0]   rs1_q, rs2_q, rs3_q;
  logic [NUM_LANES-1:0][XLEN-1:0]   lane_data;

  // a stage moves when it is empty or its successor moves, so bubbles collapse
  assign en2 = !vld_pipe_q[2] || result_ready;
  assign en1 = !vld_pipe_q[1] || en2;
  assign en0 = !vld_pipe_q[0] || en1;

  // data registers only load real ops, keeping held results stable
  assign ld0 = execute_valid && en0;
  assign ld1 = vld_pipe_q[0] && en1;
  assign ld2 = vld_pipe_q[1] && en2;

  assign execute_ready = en0;

  // valid shift register; reset discards everything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
    end else begin
      if (en0) vld_pipe_q[0] <= execute_valid;
      if (en1) vld_pipe_q[1] <= vld_pipe_q[0];
      if (en2) vld_pipe_q[2] <= vld_pipe_q[1];
    end
  end

  // S0 input register: op, operands and sideband
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op0_q    <= '0;
      tmask0_q <= '0;
      tag0_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
    end else if (ld0) begin
      op0_q    <= execute_op;
      tmask0_q <= execute_tmask;
      tag0_q   <= execute_tag;
      rs1_q    <= execute_rs1;
      rs2_q    <= execute_rs2;
      rs3_q    <= execute_rs3;
    end
  end

  // sideband follows its op through S1 and S2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmask1_q <= '0;
      tag1_q   <= '0;
      tmask2_q <= '0;
      tag2_q   <= '0;
    end else begin
      if (ld1) begin
        tmask1_q <= tmask0_q;
        tag1_q   <= tag0_q;
      end
      if (ld2) begin
        tmask2_q <= tmask1_q;
        tag2_q   <= tag1_q;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    alu_sad_lane #(.XLEN(XLEN)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .ld1_i  (ld1),
      .ld2_i  (ld2),
      .op_i   (op0_q),
      .act_i  (tmask0_q[l]),
      .rs1_i  (rs1_q[l]),
      .rs2_i  (rs2_q[l]),
      .rs3_i  (rs3_q[l]),
      .data_o (lane_data[l])
    );
  end

  assign result_valid = vld_pipe_q[2];
  assign result_tmask = tmask2_q;
  assign result_tag   = tag2_q;
  assign result_data  = lane_data;

endmodule

// File: tb/tb_alu_sad_pe.sv
// Randomized + directed bench for alu_sad_pe against an arithmetic reference.
module tb_alu_sad_pe;

  localparam int NL = 4;
  localparam int XL = 32;
  localparam int TW = 64;
  localparam int W  = NL * XL;

  logic          clk = 1'b0;
  logic          reset;
  logic          execute_valid, execute_ready;
  logic [1:0]    execute_op;
  logic [NL-1:0] execute_tmask;
  logic [TW-1:0] execute_tag;
  logic [W-1:0]  execute_rs1, execute_rs2, execute_rs3;
  logic          result_valid, result_ready;
  logic [NL-1:0] result_tmask;
  logic [TW-1:0] result_tag;
  logic [W-1:0]  result_data;

  always #5 clk = ~clk;

  alu_sad_pe #(.NUM_LANES(NL), .XLEN(XL), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .execute_valid(execute_valid), .execute_ready(execute_ready),
    .execute_op(execute_op), .execute_tmask(execute_tmask), .execute_tag(execute_tag),
    .execute_rs1(execute_rs1), .execute_rs2(execute_rs2), .execute_rs3(execute_rs3),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_tmask(result_tmask), .result_tag(result_tag), .result_data(result_data)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [NL-1:0] tmask;
    logic [W-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_acc = 0;
  bit   stalled = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // reference: plain arithmetic on unsigned bytes/halfwords
  function automatic logic [XL-1:0] ref_lane(input logic [1:0] op, input logic [XL-1:0] a,
                                             input logic [XL-1:0] b, input logic [XL-1:0] c,
                                             input bit act);
    longint s;
    int x, y;
    s = 0;
    if (!act || op == 2'd3) return '0;
    if (op == 2'd2) begin
      for (int k = 0; k < XL/16; k++) begin
        x = int'(a[16*k +: 16]);
        y = int'(b[16*k +: 16]);
        s += (x > y) ? x - y : y - x;
      end
    end else begin
      for (int k = 0; k < XL/8; k++) begin
        x = int'(a[8*k +: 8]);
        y = int'(b[8*k +: 8]);
        s += (x > y) ? x - y : y - x;
      end
      if (op == 2'd1) s += longint'(c);
    end
    return s[XL-1:0];
  endfunction

  function automatic exp_t ref_op();
    exp_t e;
    e.tag   = execute_tag;
    e.tmask = execute_tmask;
    e.data  = '0;
    for (int l = 0; l < NL; l++)
      e.data[XL*l +: XL] = ref_lane(execute_op, execute_rs1[XL*l +: XL], execute_rs2[XL*l +: XL],
                                    execute_rs3[XL*l +: XL], execute_tmask[l]);
    return e;
  endfunction

  // one cycle: called just after a negedge with inputs set; scores both handshakes
  task automatic tick();
    exp_t e;
    #1;
    if (stalled) begin
      chk("hold_valid", result_valid, 1'b1);
      if (exp_q.size() > 0) chk("hold_data", result_data, exp_q[0].data);
    end
    if (result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", result_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", result_data, e.data);
        chk("res_tag", result_tag, e.tag);
        chk("res_tmask", result_tmask, e.tmask);
      end
    end
    stalled = result_valid && !result_ready;
    if (execute_valid && execute_ready) begin
      exp_q.push_back(ref_op());
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [1:0] op, input logic [NL-1:0] tm,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    execute_op    = op;
    execute_tmask = tm;
    execute_tag   = {$urandom, $urandom};
    execute_rs1   = a;
    execute_rs2   = b;
    execute_rs3   = c;
  endtask

  task automatic set_rand();
    logic [W-1:0] a, b;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(3) == 0) b = a ^ {NL{32'h0101_0101 & $urandom}};
    set_op(2'($urandom_range(3)), NL'($urandom), a, b, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic drain();
    execute_valid = 1'b0;
    result_ready  = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    chk("drain_left", exp_q.size(), 0);
    tick();
  endtask

  // single op into an idle pipe; checks latency and a fixed expected result
  task automatic directed(input string name, input logic [1:0] op, input logic [NL-1:0] tm,
                          input logic [XL-1:0] a, input logic [XL-1:0] b, input logic [XL-1:0] c,
                          input logic [W-1:0] exp_data);
    result_ready = 1'b1;
    set_op(op, tm, {NL{a}}, {NL{b}}, {NL{c}});
    execute_valid = 1'b1;
    tick();                                   // accepted at edge N
    execute_valid = 1'b0;
    chk({name, "_lat_n"}, result_valid, 1'b0);
    tick();                                   // edge N+1
    chk({name, "_lat_n1"}, result_valid, 1'b0);
    tick();                                   // edge N+2, visible for edge N+3
    chk({name, "_valid"}, result_valid, 1'b1);
    chk({name, "_data"}, result_data, exp_data);
    tick();                                   // transferred at edge N+3
    chk({name, "_done"}, result_valid, 1'b0);
  endtask

  int base;
  int idx;

  initial begin
    reset = 1'b0;
    execute_valid = 1'b0;
    result_ready  = 1'b0;
    set_op(2'd0, '0, '0, '0, '0);
    execute_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_data", result_data, '0);
    chk("rst_tag", result_tag, '0);
    chk("rst_tmask", result_tmask, '0);
    reset = 1'b1;
    #1 chk("rst_exec_ready", execute_ready, 1'b1);
    @(negedge clk);

    directed("sad8_l0", 2'd0, 4'b0001, 32'h0102_0304, 32'h0403_0201, 32'h0, {96'h0, 32'h8});
    directed("sad8_all", 2'd0, 4'b1111, 32'hFF00_FF00, 32'h00FF_00FF, 32'h0, {NL{32'h3FC}});
    directed("sad8acc", 2'd1, 4'b1111, 32'h0102_0304, 32'h0403_0201, 32'hFFFF_FFFF, {NL{32'h7}});
    directed("sad16", 2'd2, 4'b1111, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0, {NL{32'h1_FFFE}});
    directed("rsvd", 2'd3, 4'b1111, 32'h1234_5678, 32'h8765_4321, 32'h5, '0);
    directed("tm0", 2'd1, 4'b0000, 32'h1234_5678, 32'h8765_4321, 32'h5, '0);

    // back-pressure: 5 ops offered with the consumer stalled
    result_ready = 1'b0;
    base = n_acc;
    for (int cy = 0; cy < 5; cy++) begin
      if (n_acc - base == cy) set_rand();
      execute_valid = 1'b1;
      #1;
      if (cy >= 3) chk("bp_exec_ready", execute_ready, 1'b0);
      tick();
    end
    chk("bp_accepted3", n_acc - base, 3);
    result_ready = 1'b1;
    for (int i = 0; i < 20 && n_acc - base < 5; i++) begin
      idx = n_acc - base;
      tick();
      if (n_acc - base != idx && n_acc - base < 5) set_rand();
    end
    chk("bp_accepted5", n_acc - base, 5);
    drain();

    // bubble collapse: A, two idle cycles, then B/C while A is stuck in S2
    result_ready = 1'b1;
    set_rand();
    execute_valid = 1'b1;
    tick();
    execute_valid = 1'b0;
    tick();
    tick();
    result_ready = 1'b0;
    set_rand();
    execute_valid = 1'b1;
    #1 chk("bub_b_ready", execute_ready, 1'b1);
    tick();
    set_rand();
    #1 chk("bub_c_ready", execute_ready, 1'b1);
    tick();
    set_rand();
    #1 chk("bub_d_blocked", execute_ready, 1'b0);
    tick();
    result_ready = 1'b1;
    base = n_acc;
    for (int i = 0; i < 10 && n_acc == base; i++) tick();
    chk("bub_d_accepted", n_acc - base, 1);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!(execute_valid && execute_ready)) begin
        if (!execute_valid) set_rand();
      end else begin
        set_rand();
      end
      execute_valid = ($urandom_range(3) != 0);
      result_ready  = ($urandom_range(3) != 0);
      tick();
    end
    drain();

    // asynchronous reset with three ops in flight
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      execute_valid = 1'b1;
      tick();
    end
    execute_valid = 1'b0;
    chk("mid_full", result_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_async_valid", result_valid, 1'b0);
    chk("mid_async_data", result_data, '0);
    exp_q.delete();
    stalled = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", result_valid, 1'b0);
    end
    directed("post_rst", 2'd0, 4'b1111, 32'hFF00_FF00, 32'h00FF_00FF, 32'h0, {NL{32'h3FC}});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
